// File: rtl/debug_scan_pkg.sv
// Shared types and constants for the debug scan controller and its command slot.
package debug_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAP   = 2'd1,
        SHIFT = 2'd2
    } phase_e;

    localparam int STATUS_BITS = 2;

endpackage

// File: rtl/debug_cmd_slot.sv
// One-entry valid/ready holding register for completed scan commands.
// valid/ready: a command transfers on any edge where valid && ready; data, ch and take hold while valid=1.
module debug_cmd_slot #(
    parameter int DATA_W = 38,
    parameter int IR_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [IR_W-1:0]   load_ch,
    input  logic              load_take,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [IR_W-1:0]   ch,
    output logic              take,
    output logic              full
);

    // A slot being drained this cycle counts as free, so a coincident load is accepted.
    assign full = valid && !ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            ch    <= '0;
            take  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            ch    <= load_ch;
            take  <= load_take;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/debug_slave_scan_ctrl.sv
// Debug scan controller: capture/shift/update sequencing, scan length check and sticky status.
module debug_slave_scan_ctrl
    import debug_scan_pkg::*;
#(
    parameter int DATA_W     = 38,
    parameter int IR_W       = 2,
    parameter int NUM_CH     = 4,
    parameter int LEN_CHECK  = 1,
    parameter int STATUS_CAP = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IR_W-1:0]          ir_in,
    input  logic                     vs_uir,
    input  logic                     vs_cdr,
    input  logic                     vs_sdr,
    input  logic                     vs_udr,
    input  logic                     tdi,
    output logic                     tdo,
    input  logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0]        jdo,
    output logic                     act_valid,
    input  logic                     act_ready,
    output logic [IR_W-1:0]          act_ch,
    output logic                     act_take,
    output logic                     overrun,
    output logic                     len_err
);

    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

    phase_e            phase;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] cap_val;
    logic [CNT_W-1:0]  cnt;
    logic              do_uir;
    logic              do_cdr;
    logic              do_sdr;
    logic              do_udr;
    logic              ch_ok;
    logic              len_bad;
    logic              slot_full;
    logic              cmd_load;

    // Higher-priority strobes mask the lower ones in the same cycle.
    assign do_uir = vs_uir;
    assign do_cdr = vs_cdr && !vs_uir;
    assign do_sdr = vs_sdr && !vs_uir && !vs_cdr;
    assign do_udr = vs_udr && !vs_uir && !vs_cdr && !vs_sdr;

    assign ch_ok    = {1'b0, ir_in} < (IR_W + 1)'(NUM_CH);
    assign len_bad  = (LEN_CHECK != 0) && (cnt != CNT_FULL);
    assign cmd_load = do_udr && ch_ok && !len_bad && !slot_full;
    assign tdo      = sr[0];

    always_comb begin
        cap_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ir_in == IR_W'(c)) begin
                cap_val = rd_data[c*DATA_W +: DATA_W];
            end
        end
        if (STATUS_CAP != 0) begin
            cap_val[DATA_W-1 -: STATUS_BITS] = {overrun, len_err};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
            len_err <= 1'b0;
        end else if (do_uir) begin
            phase   <= IDLE;
            cnt     <= '0;
            overrun <= 1'b0;
            len_err <= 1'b0;
        end else if (do_cdr) begin
            phase <= CAP;
            sr    <= cap_val;
            cnt   <= '0;
        end else if (do_sdr) begin
            sr <= {tdi, sr[DATA_W-1:1]};
            if (cnt != CNT_SAT) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (phase == CAP) begin
                phase <= SHIFT;
            end
        end else if (do_udr) begin
            phase <= IDLE;
            if (ch_ok) begin
                if (len_bad) begin
                    len_err <= 1'b1;
                end else if (slot_full) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    debug_cmd_slot #(
        .DATA_W (DATA_W),
        .IR_W   (IR_W)
    ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (cmd_load),
        .load_data (sr),
        .load_ch   (ir_in),
        .load_take (sr[DATA_W-1]),
        .ready     (act_ready),
        .valid     (act_valid),
        .data      (jdo),
        .ch        (act_ch),
        .take      (act_take),
        .full      (slot_full)
    );

endmodule

// File: tb/tb_debug_slave_scan_ctrl.sv
// Bench for debug_slave_scan_ctrl: directed scenarios plus random scan traffic against a reference model.
module tb_debug_slave_scan_ctrl;

    localparam int DW = 38;
    localparam int IW = 2;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] ir_in;
    logic          vs_uir, vs_cdr, vs_sdr, vs_udr, tdi;
    logic          tdo;
    logic [NC*DW-1:0] rd_data;
    logic [DW-1:0] jdo;
    logic          act_valid, act_ready, act_take, overrun, len_err;
    logic [IW-1:0] act_ch;

    logic          tdo3, act_valid3, act_take3, overrun3, len_err3;
    logic [DW-1:0] jdo3;
    logic [IW-1:0] act_ch3;

    logic          rst_req = 1'b0;
    logic          rdy = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] m_sr, m_jdo;
    logic [IW-1:0] m_ch;
    logic          m_valid, m_take, m_ov, m_le;
    int            m_cnt;

    always #5 clk = ~clk;

    debug_slave_scan_ctrl #(.DATA_W(DW), .IR_W(IW), .NUM_CH(NC), .LEN_CHECK(1), .STATUS_CAP(1)) u_dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
        .vs_sdr(vs_sdr), .vs_udr(vs_udr), .tdi(tdi), .tdo(tdo), .rd_data(rd_data),
        .jdo(jdo), .act_valid(act_valid), .act_ready(act_ready), .act_ch(act_ch),
        .act_take(act_take), .overrun(overrun), .len_err(len_err)
    );

    debug_slave_scan_ctrl #(.DATA_W(DW), .IR_W(IW), .NUM_CH(3), .LEN_CHECK(1), .STATUS_CAP(1)) u_dut3 (
        .clk(clk), .reset(reset), .ir_in(ir_in), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
        .vs_sdr(vs_sdr), .vs_udr(vs_udr), .tdi(tdi), .tdo(tdo3), .rd_data(rd_data[3*DW-1:0]),
        .jdo(jdo3), .act_valid(act_valid3), .act_ready(act_ready), .act_ch(act_ch3),
        .act_take(act_take3), .overrun(overrun3), .len_err(len_err3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic accept;
        accept = 1'b0;
        if (reset) begin
            m_sr = '0; m_jdo = '0; m_ch = '0; m_valid = 0; m_take = 0;
            m_ov = 0; m_le = 0; m_cnt = 0;
            return;
        end
        if (vs_uir) begin
            m_ov = 0; m_le = 0; m_cnt = 0;
        end else if (vs_cdr) begin
            m_sr = (int'(ir_in) < NC) ? rd_data[int'(ir_in)*DW +: DW] : '0;
            m_sr[DW-1] = m_ov;
            m_sr[DW-2] = m_le;
            m_cnt = 0;
        end else if (vs_sdr) begin
            m_sr = {tdi, m_sr[DW-1:1]};
            m_cnt = (m_cnt >= DW + 1) ? DW + 1 : m_cnt + 1;
        end else if (vs_udr) begin
            if (m_cnt != DW) m_le = 1;
            else if (m_valid && !act_ready) m_ov = 1;
            else accept = 1'b1;
        end
        if (accept) begin
            m_valid = 1; m_jdo = m_sr; m_ch = ir_in; m_take = m_sr[DW-1];
        end else if (m_valid && act_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("tdo", 64'(tdo), 64'(m_sr[0]));
        check("act_valid", 64'(act_valid), 64'(m_valid));
        check("jdo", 64'(jdo), 64'(m_jdo));
        check("act_ch", 64'(act_ch), 64'(m_ch));
        check("act_take", 64'(act_take), 64'(m_take));
        check("overrun", 64'(overrun), 64'(m_ov));
        check("len_err", 64'(len_err), 64'(m_le));
    endtask

    // One clock: drive at negedge, model at posedge, compare just after the edge.
    task automatic cyc(input logic u, input logic c, input logic s, input logic d, input logic t);
        @(negedge clk);
        reset = rst_req; act_ready = rdy;
        vs_uir = u; vs_cdr = c; vs_sdr = s; vs_udr = d; tdi = t;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic full_cmd(input logic [IW-1:0] ch, input logic [DW-1:0] pat);
        ir_in = ch;
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < DW; i++) cyc(0, 0, 1, 0, pat[i]);
        cyc(0, 0, 0, 1, 0);
    endtask

    initial begin
        logic [DW-1:0] pat_a, pat_b, obs;
        int n;
        reset = 1; ir_in = 0; vs_uir = 0; vs_cdr = 0; vs_sdr = 0; vs_udr = 0; tdi = 0;
        act_ready = 0; rd_data = '0;

        rst_req = 1; idle(); idle(); rst_req = 0;
        check("reset_valid", 64'(act_valid), 64'(0));
        check("reset_jdo", 64'(jdo), 64'(0));

        // 1. Normal command
        pat_a = 38'h20_0000_00AB;
        full_cmd(2'd2, pat_a);
        check("t1_valid", 64'(act_valid), 64'(1));
        check("t1_ch", 64'(act_ch), 64'(2));
        check("t1_take", 64'(act_take), 64'(1));
        check("t1_jdo", 64'(jdo), 64'(38'h20_0000_00AB));

        // 2. Capture and shift out
        rd_data[1*DW +: DW] = 38'h0_1234_5678;
        ir_in = 1;
        cyc(0, 1, 0, 0, 0);
        obs[0] = tdo;
        for (int i = 1; i < DW; i++) begin
            cyc(0, 0, 1, 0, 0);
            obs[i] = tdo;
        end
        cyc(0, 0, 1, 0, 0);
        check("t2_shift_out", 64'(obs), 64'(38'h0_1234_5678));

        // 3. Length error
        rdy = 1; idle(); rdy = 0;
        check("t3_drained", 64'(act_valid), 64'(0));
        ir_in = 0;
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < DW - 1; i++) cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 0);
        check("t3_valid", 64'(act_valid), 64'(0));
        check("t3_len_err", 64'(len_err), 64'(1));
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < DW - 2; i++) cyc(0, 0, 1, 0, 0);
        check("t3_cap_len_err", 64'(tdo), 64'(1));
        cyc(1, 0, 0, 0, 0);
        check("t3_uir_clear", 64'(len_err), 64'(0));

        // 4. Overrun
        pat_a = 38'h15_5555_1234;
        pat_b = 38'h0A_AAAA_4321;
        full_cmd(2'd1, pat_a);
        check("t4_first_valid", 64'(act_valid), 64'(1));
        full_cmd(2'd3, pat_b);
        check("t4_overrun", 64'(overrun), 64'(1));
        check("t4_jdo_kept", 64'(jdo), 64'(pat_a));
        check("t4_ch_kept", 64'(act_ch), 64'(1));
        rdy = 1; idle(); rdy = 0;
        check("t4_drain", 64'(act_valid), 64'(0));

        // 5. Handshake-coincident update
        cyc(1, 0, 0, 0, 0);
        full_cmd(2'd0, pat_a);
        ir_in = 2;
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < DW; i++) cyc(0, 0, 1, 0, pat_b[i]);
        rdy = 1;
        cyc(0, 0, 0, 1, 0);
        rdy = 0;
        check("t5_valid", 64'(act_valid), 64'(1));
        check("t5_jdo_new", 64'(jdo), 64'(pat_b));
        check("t5_overrun", 64'(overrun), 64'(0));

        // 6. Reset mid-operation, then the unimplemented channel on the 3-channel instance
        ir_in = 1;
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 1);
        check("t6_pre_valid", 64'(act_valid), 64'(1));
        rst_req = 1; idle(); rst_req = 0;
        check("t6_rst_all", 64'({tdo, act_valid, jdo, act_ch, act_take, overrun, len_err}), 64'(0));
        check("t6_rst_dut3", 64'({tdo3, act_valid3, jdo3, overrun3, len_err3}), 64'(0));
        rd_data = {38'h3F_FFFF_FFFF, 38'h2A_5A5A_5A5A, 38'h15_A5A5_A5A5, 38'h3F_0000_FFFF};
        ir_in = 3;
        cyc(0, 1, 0, 0, 0);
        obs[0] = tdo3;
        for (int i = 1; i < DW; i++) begin
            cyc(0, 0, 1, 0, 0);
            obs[i] = tdo3;
        end
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check("t6_unimpl_sr", 64'(obs), 64'(0));
        check("t6_unimpl_valid", 64'(act_valid3), 64'(0));
        check("t6_unimpl_flags", 64'({overrun3, len_err3}), 64'(0));

        // Random command sequences
        for (int k = 0; k < 40; k++) begin
            for (int c = 0; c < NC; c++) rd_data[c*DW +: DW] = {$urandom, $urandom};
            ir_in = IW'($urandom_range(0, NC - 1));
            rdy = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) cyc(1, 0, 0, 0, 0);
            cyc(0, 1, 0, 0, 0);
            case ($urandom_range(0, 5))
                0: n = DW - 1;
                1: n = DW + 1 + $urandom_range(0, 2);
                2: n = $urandom_range(0, 4);
                default: n = DW;
            endcase
            for (int i = 0; i < n; i++) begin
                rdy = ($urandom_range(0, 3) == 0);
                cyc(0, 0, 1, 0, 1'($urandom));
            end
            rdy = ($urandom_range(0, 1) == 0);
            cyc(0, 0, 0, 1, 0);
        end

        // Random strobe soup, including several strobes in one cycle
        for (int k = 0; k < 400; k++) begin
            ir_in = IW'($urandom_range(0, NC - 1));
            rdy = ($urandom_range(0, 3) == 0);
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 1) == 0, $urandom_range(0, 5) == 0, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
